// File: rtl/icache_pkg.sv
// Shared types and width helpers for the instruction cache refill block.
package icache_pkg;

  // Refill controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_FILL = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Byte-offset width of a line (word select plus the two byte bits).
  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  // Line index width.
  function automatic int calc_idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: whatever address bits remain above index and offset.
  function automatic int calc_tag_w(input int addr_w, input int lines, input int line_words);
    return addr_w - calc_idx_w(lines) - calc_off_w(line_words);
  endfunction

endpackage

// File: rtl/icache_data_ram.sv
// Instruction data store: one write port used by the refill engine,
// one asynchronous read port used by the zero-latency fetch lookup.
module icache_data_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Refill beats land here one word per cycle.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_refill.sv
// Direct-mapped instruction cache with a single outstanding line refill.
// Optional statistics counters are built when ICACHE_STATS_EN is defined;
// otherwise HIT_CNT and MISS_CNT are constant zero.
module icache_refill
  import icache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] FE_PC,
  input  logic              FE_REQ,
  output logic              FE_HIT,
  output logic [31:0]       FE_INSTR,
  output logic              FE_IAF,
  input  logic              FLUSH,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic              MEM_RVALID,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ERR,
  output logic [31:0]       HIT_CNT,
  output logic [31:0]       MISS_CNT
);

  localparam int OFF_W  = calc_off_w(LINE_WORDS);
  localparam int IDX_W  = calc_idx_w(LINES);
  localparam int TAG_W  = calc_tag_w(ADDR_W, LINES, LINE_WORDS);
  localparam int WSEL_W = OFF_W - 2;
  localparam int LNUM_W = ADDR_W - OFF_W;
  localparam int RAM_AW = IDX_W + WSEL_W;
  localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(LINE_WORDS - 1);

  state_t              state_reg, state_next;
  logic [WSEL_W-1:0]   beat_reg, beat_next;
  logic [LNUM_W-1:0]   line_num_reg, line_num_next;
  logic                mem_req_reg, mem_req_next;
  logic                flush_pend_reg, flush_pend_next;

  logic                ram_we;
  logic                fill_set_valid;
  logic                miss_start;

  logic [LINES-1:0]    valid_vec;
  logic [TAG_W-1:0]    tag_mem [LINES];

  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [WSEL_W-1:0]   pc_wsel;
  logic [LNUM_W-1:0]   pc_line;
  logic                pc_aligned;
  logic                lookup_hit;
  logic                in_line;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;
  logic [31:0]         ram_rdata;

  assign pc_idx     = FE_PC[OFF_W +: IDX_W];
  assign pc_tag     = FE_PC[ADDR_W-1 -: TAG_W];
  assign pc_wsel    = FE_PC[2 +: WSEL_W];
  assign pc_line    = FE_PC[ADDR_W-1:OFF_W];
  assign pc_aligned = (FE_PC[1:0] == 2'b00);

  assign fill_idx = line_num_reg[IDX_W-1:0];
  assign fill_tag = line_num_reg[LNUM_W-1:IDX_W];
  assign in_line  = (pc_line == line_num_reg);

  // A faulted line blocks every hit until the fetch stage moves on.
  assign lookup_hit = valid_vec[pc_idx] && (tag_mem[pc_idx] == pc_tag) &&
                      pc_aligned && (state_reg != ST_ERR);

  assign FE_HIT   = FE_REQ && lookup_hit;
  assign FE_INSTR = FE_HIT ? ram_rdata : 32'd0;
  assign FE_IAF   = (state_reg == ST_ERR) && FE_REQ && in_line;
  assign MEM_REQ  = mem_req_reg;
  assign MEM_ADDR = {line_num_reg, {OFF_W{1'b0}}};

  icache_data_ram #(
    .DEPTH(LINES * LINE_WORDS),
    .AW   (RAM_AW)
  ) u_data_ram (
    .CLK  (CLK),
    .we   (ram_we),
    .waddr({fill_idx, beat_reg}),
    .wdata(MEM_RDATA),
    .raddr({pc_idx, pc_wsel}),
    .rdata(ram_rdata)
  );

  // Controller state, latched line and bus request register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      beat_reg       <= '0;
      line_num_reg   <= '0;
      mem_req_reg    <= 1'b0;
      flush_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      beat_reg       <= beat_next;
      line_num_reg   <= line_num_next;
      mem_req_reg    <= mem_req_next;
      flush_pend_reg <= flush_pend_next;
    end
  end

  // Next-state logic and per-cycle strobes for the refill engine.
  always_comb begin
    state_next      = state_reg;
    beat_next       = beat_reg;
    line_num_next   = line_num_reg;
    mem_req_next    = mem_req_reg;
    flush_pend_next = flush_pend_reg;
    ram_we          = 1'b0;
    fill_set_valid  = 1'b0;
    miss_start      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (FE_REQ && !lookup_hit && pc_aligned && !FLUSH) begin
          state_next      = ST_REQ;
          line_num_next   = pc_line;
          mem_req_next    = 1'b1;
          flush_pend_next = 1'b0;
          miss_start      = 1'b1;
        end
      end
      ST_REQ: begin
        if (FLUSH) begin
          flush_pend_next = 1'b1;
        end
        if (MEM_ACK) begin
          state_next   = ST_FILL;
          beat_next    = '0;
          mem_req_next = 1'b0;
        end
      end
      ST_FILL: begin
        if (FLUSH) begin
          flush_pend_next = 1'b1;
        end
        if (MEM_RVALID) begin
          if (MEM_ERR) begin
            // Remaining beats are dropped by the bus; nothing more to wait for.
            state_next = ST_ERR;
            beat_next  = '0;
          end else begin
            ram_we = 1'b1;
            if (beat_reg == LAST_BEAT) begin
              state_next     = ST_IDLE;
              beat_next      = '0;
              // A flush seen at any point of the fill, including this beat, wins.
              fill_set_valid = !flush_pend_reg && !FLUSH;
            end else begin
              beat_next = beat_reg + 1'b1;
            end
          end
        end
      end
      ST_ERR: begin
        if (!FE_REQ || !in_line || FLUSH) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Tag store: written once the whole line has arrived cleanly.
  always_ff @(posedge CLK) begin
    if (fill_set_valid) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  // One valid bit per line; the victim line is invalidated as its refill starts.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    logic valid_bit_reg;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        valid_bit_reg <= 1'b0;
      end else if (FLUSH) begin
        valid_bit_reg <= 1'b0;
      end else if (fill_set_valid && (fill_idx == IDX_W'(gi))) begin
        valid_bit_reg <= 1'b1;
      end else if (miss_start && (pc_idx == IDX_W'(gi))) begin
        valid_bit_reg <= 1'b0;
      end
    end

    assign valid_vec[gi] = valid_bit_reg;
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;

  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (FE_HIT) begin
        hit_cnt_reg <= hit_cnt_reg + 32'd1;
      end
      if (miss_start) begin
        miss_cnt_reg <= miss_cnt_reg + 32'd1;
      end
    end
  end

  assign HIT_CNT  = hit_cnt_reg;
  assign MISS_CNT = miss_cnt_reg;
`else
  assign HIT_CNT  = 32'd0;
  assign MISS_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: cold miss, conflict, misalignment,
// bus error, flush on the last beat and reset during a fill.
module tb_icache_refill;

  localparam int LINES      = 16;
  localparam int LINE_WORDS = 4;
  localparam int ADDR_W     = 64;
`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [ADDR_W-1:0] FE_PC = '0;
  logic              FE_REQ = 1'b0;
  logic              FE_HIT;
  logic [31:0]       FE_INSTR;
  logic              FE_IAF;
  logic              FLUSH = 1'b0;
  logic              MEM_REQ;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic              MEM_ACK = 1'b0;
  logic              MEM_RVALID = 1'b0;
  logic [31:0]       MEM_RDATA = '0;
  logic              MEM_ERR = 1'b0;
  logic [31:0]       HIT_CNT;
  logic [31:0]       MISS_CNT;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 CLK = ~CLK;

  icache_refill #(
    .LINES(LINES), .LINE_WORDS(LINE_WORDS), .ADDR_W(ADDR_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FE_PC(FE_PC), .FE_REQ(FE_REQ), .FE_HIT(FE_HIT),
    .FE_INSTR(FE_INSTR), .FE_IAF(FE_IAF), .FLUSH(FLUSH), .MEM_REQ(MEM_REQ),
    .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RVALID(MEM_RVALID),
    .MEM_RDATA(MEM_RDATA), .MEM_ERR(MEM_ERR), .HIT_CNT(HIT_CNT), .MISS_CNT(MISS_CNT)
  );

  // Advance to 1 time unit after the next rising edge.
  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  // Bus responder: waits (bounded) for MEM_REQ, acks at once, then streams
  // d0, d0+1, ... back to back. Stops after err_beat when it is in range.
  task automatic fill_line(input logic [31:0] d0, input int err_beat, input bit flush_last,
                           output bit ok, output logic [ADDR_W-1:0] addr_seen);
    ok = 1'b0;
    addr_seen = '0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (MEM_REQ) begin
        ok = 1'b1;
        break;
      end
      step;
    end
    if (!ok) return;
    addr_seen = MEM_ADDR;
    MEM_ACK = 1'b1;
    step;
    MEM_ACK = 1'b0;
    for (int b = 0; b < LINE_WORDS; b++) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = d0 + 32'(b);
      MEM_ERR    = (b == err_beat);
      FLUSH      = flush_last && (b == LINE_WORDS - 1);
      step;
      if (b == err_beat) break;
    end
    MEM_RVALID = 1'b0;
    MEM_ERR    = 1'b0;
    MEM_RDATA  = '0;
    FLUSH      = 1'b0;
    $display("fill 0x%0h data base 0x%0h err_beat %0d flush_last %0b", addr_seen, d0, err_beat, flush_last);
  endtask

  task automatic test_reset;
    RESET = 1'b1;
    FE_PC = 64'h1000;
    FE_REQ = 1'b1;
    step;
    step;
    vec_cnt++; if (MEM_REQ !== 1'b0) begin err_cnt++; $display("FAIL reset_mem_req: got %0b want 0", MEM_REQ); end
    vec_cnt++; if (MEM_ADDR !== 64'h0) begin err_cnt++; $display("FAIL reset_mem_addr: got 0x%0h want 0", MEM_ADDR); end
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL reset_hit: got %0b want 0", FE_HIT); end
    vec_cnt++; if (FE_IAF !== 1'b0) begin err_cnt++; $display("FAIL reset_iaf: got %0b want 0", FE_IAF); end
    vec_cnt++; if (HIT_CNT !== 32'd0 || MISS_CNT !== 32'd0) begin err_cnt++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", HIT_CNT, MISS_CNT); end
    FE_REQ = 1'b0;
    RESET = 1'b0;
    step;
    $display("reset done");
  endtask

  task automatic test_cold_miss;
    FE_PC = 64'h1000;
    FE_REQ = 1'b1;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL cold_c0_hit: got %0b want 0", FE_HIT); end
    vec_cnt++; if (MEM_REQ !== 1'b0) begin err_cnt++; $display("FAIL cold_c0_req: got %0b want 0", MEM_REQ); end
    step;
    #1;
    vec_cnt++; if (MEM_REQ !== 1'b1) begin err_cnt++; $display("FAIL cold_c1_req: got %0b want 1", MEM_REQ); end
    vec_cnt++; if (MEM_ADDR !== 64'h1000) begin err_cnt++; $display("FAIL cold_addr: got 0x%0h want 0x1000", MEM_ADDR); end
    MEM_ACK = 1'b1;
    step;
    MEM_ACK = 1'b0;
    vec_cnt++; if (MEM_REQ !== 1'b0) begin err_cnt++; $display("FAIL cold_req_drop: got %0b want 0", MEM_REQ); end
    for (int b = 0; b < LINE_WORDS; b++) begin
      MEM_RVALID = 1'b1;
      MEM_RDATA  = 32'hA0 + 32'(b);
      #1;
      vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL cold_beat%0d_hit: got %0b want 0", b, FE_HIT); end
      step;
    end
    MEM_RVALID = 1'b0;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1) begin err_cnt++; $display("FAIL cold_c6_hit: got %0b want 1", FE_HIT); end
    vec_cnt++; if (FE_INSTR !== 32'hA0) begin err_cnt++; $display("FAIL cold_c6_instr: got 0x%0h want 0xa0", FE_INSTR); end
    step;
    FE_PC = 64'h100C;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hA3) begin err_cnt++; $display("FAIL cold_100c: got hit %0b instr 0x%0h want 1 0xa3", FE_HIT, FE_INSTR); end
    step;
    FE_REQ = 1'b0;
    #1;
    vec_cnt++; if (MEM_REQ !== 1'b0) begin err_cnt++; $display("FAIL cold_100c_req: got %0b want 0", MEM_REQ); end
    vec_cnt++; if (HIT_CNT !== (STATS ? 32'd2 : 32'd0)) begin err_cnt++; $display("FAIL cold_hit_cnt: got %0d want %0d", HIT_CNT, STATS ? 2 : 0); end
    vec_cnt++; if (MISS_CNT !== (STATS ? 32'd1 : 32'd0)) begin err_cnt++; $display("FAIL cold_miss_cnt: got %0d want %0d", MISS_CNT, STATS ? 1 : 0); end
    $display("cold miss 0x1000 done");
  endtask

  task automatic test_conflict;
    bit ok;
    logic [ADDR_W-1:0] addr;
    FE_PC = 64'h1100;
    FE_REQ = 1'b1;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL conf_1100_miss: got %0b want 0", FE_HIT); end
    fill_line(32'hB0, -1, 1'b0, ok, addr);
    vec_cnt++; if (ok !== 1'b1 || addr !== 64'h1100) begin err_cnt++; $display("FAIL conf_fill_1100: got ok %0b addr 0x%0h want 1 0x1100", ok, addr); end
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hB0) begin err_cnt++; $display("FAIL conf_1100_hit: got %0b 0x%0h want 1 0xb0", FE_HIT, FE_INSTR); end
    step;
    FE_PC = 64'h1000;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL conf_1000_miss: got %0b want 0", FE_HIT); end
    fill_line(32'hA0, -1, 1'b0, ok, addr);
    vec_cnt++; if (ok !== 1'b1 || addr !== 64'h1000) begin err_cnt++; $display("FAIL conf_fill_1000: got ok %0b addr 0x%0h want 1 0x1000", ok, addr); end
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hA0) begin err_cnt++; $display("FAIL conf_1000_hit: got %0b 0x%0h want 1 0xa0", FE_HIT, FE_INSTR); end
    vec_cnt++; if (MISS_CNT !== (STATS ? 32'd3 : 32'd0)) begin err_cnt++; $display("FAIL conf_miss_cnt: got %0d want %0d", MISS_CNT, STATS ? 3 : 0); end
    step;
    FE_REQ = 1'b0;
    $display("conflict 0x1000/0x1100 done");
  endtask

  task automatic test_misaligned;
    FE_PC = 64'h1002;
    FE_REQ = 1'b1;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0 || FE_INSTR !== 32'h0) begin err_cnt++; $display("FAIL mis_hit: got %0b 0x%0h want 0 0", FE_HIT, FE_INSTR); end
    vec_cnt++; if (FE_IAF !== 1'b0) begin err_cnt++; $display("FAIL mis_iaf: got %0b want 0", FE_IAF); end
    step;
    step;
    vec_cnt++; if (MEM_REQ !== 1'b0) begin err_cnt++; $display("FAIL mis_req: got %0b want 0", MEM_REQ); end
    FE_PC = 64'h1004;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hA1) begin err_cnt++; $display("FAIL mis_1004_hit: got %0b 0x%0h want 1 0xa1", FE_HIT, FE_INSTR); end
    step;
    FE_REQ = 1'b0;
    $display("misaligned 0x1002 done");
  endtask

  task automatic test_bus_error;
    bit ok;
    logic [ADDR_W-1:0] addr;
    FE_PC = 64'h2000;
    FE_REQ = 1'b1;
    fill_line(32'hE0, 2, 1'b0, ok, addr);
    vec_cnt++; if (ok !== 1'b1 || addr !== 64'h2000) begin err_cnt++; $display("FAIL err_fill: got ok %0b addr 0x%0h want 1 0x2000", ok, addr); end
    FE_PC = 64'h2004;
    #1;
    vec_cnt++; if (FE_IAF !== 1'b1) begin err_cnt++; $display("FAIL err_iaf: got %0b want 1", FE_IAF); end
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL err_hit: got %0b want 0", FE_HIT); end
    step;
    #1;
    vec_cnt++; if (FE_IAF !== 1'b1 || MEM_REQ !== 1'b0) begin err_cnt++; $display("FAIL err_hold: got iaf %0b req %0b want 1 0", FE_IAF, MEM_REQ); end
    FE_PC = 64'h3000;
    #1;
    vec_cnt++; if (FE_IAF !== 1'b0) begin err_cnt++; $display("FAIL err_leave_iaf: got %0b want 0", FE_IAF); end
    fill_line(32'hD0, -1, 1'b0, ok, addr);
    vec_cnt++; if (ok !== 1'b1 || addr !== 64'h3000) begin err_cnt++; $display("FAIL err_refill: got ok %0b addr 0x%0h want 1 0x3000", ok, addr); end
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hD0) begin err_cnt++; $display("FAIL err_3000_hit: got %0b 0x%0h want 1 0xd0", FE_HIT, FE_INSTR); end
    step;
    FE_REQ = 1'b0;
    $display("bus error 0x2000 done");
  endtask

  task automatic test_flush_last;
    bit ok;
    logic [ADDR_W-1:0] addr;
    FE_PC = 64'h4040;
    FE_REQ = 1'b1;
    fill_line(32'hF0, -1, 1'b1, ok, addr);
    vec_cnt++; if (ok !== 1'b1 || addr !== 64'h4040) begin err_cnt++; $display("FAIL flush_fill: got ok %0b addr 0x%0h want 1 0x4040", ok, addr); end
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL flush_hit: got %0b want 0", FE_HIT); end
    step;
    #1;
    vec_cnt++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 64'h4040) begin err_cnt++; $display("FAIL flush_remiss: got req %0b addr 0x%0h want 1 0x4040", MEM_REQ, MEM_ADDR); end
    fill_line(32'hF0, -1, 1'b0, ok, addr);
    vec_cnt++; if (ok !== 1'b1) begin err_cnt++; $display("FAIL flush_refill: got ok %0b want 1", ok); end
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hF0) begin err_cnt++; $display("FAIL flush_4040_hit: got %0b 0x%0h want 1 0xf0", FE_HIT, FE_INSTR); end
    FE_PC = 64'h3000;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL flush_3000_gone: got %0b want 0", FE_HIT); end
    FE_REQ = 1'b0;
    step;
    $display("flush on last beat 0x4040 done");
  endtask

  task automatic test_reset_mid_fill;
    bit ok;
    logic [ADDR_W-1:0] addr;
    FE_PC = 64'h5000;
    FE_REQ = 1'b1;
    step;
    #1;
    vec_cnt++; if (MEM_REQ !== 1'b1 || MEM_ADDR !== 64'h5000) begin err_cnt++; $display("FAIL rst_req: got %0b 0x%0h want 1 0x5000", MEM_REQ, MEM_ADDR); end
    MEM_ACK = 1'b1;
    step;
    MEM_ACK = 1'b0;
    MEM_RVALID = 1'b1;
    MEM_RDATA = 32'h99;
    step;
    MEM_RDATA = 32'h98;
    step;
    MEM_RVALID = 1'b0;
    #2;
    RESET = 1'b1;
    FE_PC = 64'h4040;
    #1;
    vec_cnt++; if (MEM_REQ !== 1'b0 || MEM_ADDR !== 64'h0) begin err_cnt++; $display("FAIL rst_async: got req %0b addr 0x%0h want 0 0", MEM_REQ, MEM_ADDR); end
    vec_cnt++; if (HIT_CNT !== 32'd0 || MISS_CNT !== 32'd0) begin err_cnt++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", HIT_CNT, MISS_CNT); end
    step;
    RESET = 1'b0;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b0) begin err_cnt++; $display("FAIL rst_4040_miss: got %0b want 0", FE_HIT); end
    fill_line(32'hC0, -1, 1'b0, ok, addr);
    vec_cnt++; if (ok !== 1'b1 || addr !== 64'h4040) begin err_cnt++; $display("FAIL rst_refill: got ok %0b addr 0x%0h want 1 0x4040", ok, addr); end
    FE_PC = 64'h4048;
    #1;
    vec_cnt++; if (FE_HIT !== 1'b1 || FE_INSTR !== 32'hC2) begin err_cnt++; $display("FAIL rst_4048_hit: got %0b 0x%0h want 1 0xc2", FE_HIT, FE_INSTR); end
    FE_REQ = 1'b0;
    step;
    $display("reset mid fill done");
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_conflict;
    test_misaligned;
    test_bus_error;
    test_flush_last;
    test_reset_mid_fill;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icache_refill.md
# icache_refill

Direct-mapped instruction cache with a line-refill state machine. It answers the fetch stage's per-cycle PC lookup with a combinational hit and instruction word. On a miss it fetches the whole line from the backing memory port and then serves the retried PC. It sits between fetch and the memory/bus interface and is the responder side of the fetch→cache lookup.

## Interface
Parameters:
- LINES, 16: number of cache lines; power of two.
- LINE_WORDS, 4: 32-bit words per line; power of two, at least 2.
- ADDR_W, 64: PC/address width.

Ports:
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FE_PC  in  ADDR_W  fetch address.
- FE_REQ  in  1  fetch wants an instruction this cycle.
- FE_HIT  out  1  FE_INSTR is valid for FE_PC this cycle (combinational).
- FE_INSTR  out  32  instruction word at FE_PC; 0 when FE_HIT=0.
- FE_IAF  out  1  instruction access fault for FE_PC.
- FLUSH  in  1  invalidate all lines (fence.i).
- MEM_REQ  out  1  line-read request.
- MEM_ADDR  out  ADDR_W  line base address; low offset bits are 0.
- MEM_ACK  in  1  request accepted.
- MEM_RVALID  in  1  one data beat is valid.
- MEM_RDATA  in  32  beat data, in ascending word order.
- MEM_ERR  in  1  bus error on the current beat; qualified by MEM_RVALID.
- HIT_CNT, MISS_CNT  out  32  statistics counters; see Configuration.

## Operation
- Address split:
  - OFF_W = log2(LINE_WORDS*4).
  - IDX_W = log2(LINES).
  - TAG_W = ADDR_W - IDX_W - OFF_W.
  - Word select is PC[OFF_W-1:2].
- Hit: FE_HIT = FE_REQ & valid[idx] & tag[idx]==PC tag & PC[1:0]==0 & state != ERR.
- Misaligned PC (PC[1:0]!=0): never a hit and never starts a fill. Fetch raises the misalignment exception itself.
- States:
  - IDLE: on FE_REQ & !hit & aligned & !FLUSH, latch the line address and go to REQ.
  - REQ: MEM_REQ=1 and MEM_ADDR=latched base. On MEM_ACK, go to FILL with beat=0.
  - FILL: on each MEM_RVALID, write MEM_RDATA to word[beat] and increment beat.
    - On the last beat without error: write the tag, set valid, go to IDLE.
    - On MEM_RVALID & MEM_ERR: leave valid=0 and go to ERR. Remaining beats are not awaited; the bus discards them.
  - ERR: FE_IAF=1 while FE_REQ and FE_PC is in the latched line. Return to IDLE when FE_PC leaves that line, FE_REQ drops, or FLUSH is asserted.
- During a fill the latched address governs. FE_PC changes do not abort the fill; IDLE re-evaluates the new PC afterward.
- FLUSH:
  - Clears all valid bits at the edge.
  - If asserted in REQ or FILL, the fill runs to completion on the bus but the line is not marked valid.
  - A FLUSH in the same cycle as the last beat wins: the line stays invalid.
- Reset values:
  - State IDLE; all valid=0; beat=0.
  - MEM_REQ=0, MEM_ADDR=0, FE_IAF=0, counters=0.
  - Data and tag arrays are not reset.
- Reset mid-fill abandons the transaction. The memory side is reset by the same RESET.

## Timing
- Hit: same cycle as FE_PC, zero latency.
- Miss observed in cycle 0:
  - MEM_REQ is high from cycle 1 (registered).
  - With MEM_ACK in cycle 1 and back-to-back beats in cycles 2..LINE_WORDS+1, FE_HIT rises in cycle LINE_WORDS+2.
- MEM_REQ and MEM_ADDR hold stable until the MEM_ACK cycle. MEM_REQ drops the cycle after MEM_ACK.
- Gaps between beats are allowed. The beat counter wraps to 0 only on transition out of FILL.

## Configuration
- ICACHE_STATS_EN defined:
  - HIT_CNT increments on every cycle with FE_HIT=1.
  - MISS_CNT increments on every IDLE→REQ transition.
  - Both are 32-bit and wrap modulo 2^32; reset to 0.
- Undefined: HIT_CNT and MISS_CNT are tied to 0 and no counter logic is built.

## Structure
- icache_pkg holds:
  - State enum (IDLE, REQ, FILL, ERR).
  - Derived widths OFF_W, IDX_W, TAG_W as functions of the parameters.
- One sub-module, icache_data_ram:
  - LINES*LINE_WORDS x 32.
  - Synchronous write, asynchronous read.
- Tags and valid bits stay in the top level.

## Test plan
- Cold miss at PC 0x1000, ACK immediate, beats 0xA0..0xA3 back-to-back → MEM_ADDR=0x1000; FE_HIT first at cycle 6; FE_INSTR=0xA0; PC 0x100C then hits with 0xA3 and no MEM_REQ.
- Conflict: fill 0x1000, then request 0x1100 (same index, LINES=16) → miss and refill; a later 0x1000 misses again (MISS_CNT=3 with ICACHE_STATS_EN).
- MEM_ERR on beat 2 of a fill at 0x2000 → FE_IAF=1 while PC=0x2004; FE_HIT stays 0; PC moves to 0x3000 → FE_IAF=0 and a new fill starts.
- FLUSH in the cycle of the last beat → line stays invalid and the same PC misses again next cycle.
- Misaligned PC 0x1002 → FE_HIT=0, no MEM_REQ, FE_IAF=0.
- RESET asserted mid-FILL, asynchronously between edges → MEM_REQ=0 immediately; all lines miss afterward; counters read 0.
